// File: rtl/ws2812_if.sv
// Pixel-fetch and LED-line signals between the WS2812B driver and its
// surroundings. The optional brightness input exists only when
// WS2812_BRIGHTNESS_EN is defined.
interface ws2812_if #(
  parameter int NUM_PIXELS = 64
);
  localparam int ADDR_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic              start;       // 1-cycle pulse: begin a frame
  logic [ADDR_W-1:0] pixel_addr;  // frame-store read address
  logic [23:0]       pixel_data;  // GRB word, valid 1 clk after pixel_addr
  logic              busy;        // high from accepted start to end of latch
  logic              frame_done;  // 1-cycle pulse in the last latch clk
  logic              ws_dout;     // serial data to the LED chain
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]        brightness;  // global scale, sampled at word load

  // Upstream side: colour stage / frame store
  modport master (
    output start, pixel_data, brightness,
    input  pixel_addr, busy, frame_done, ws_dout
  );

  // Driver side
  modport slave (
    input  start, pixel_data, brightness,
    output pixel_addr, busy, frame_done, ws_dout
  );
`else
  // Upstream side: colour stage / frame store
  modport master (
    output start, pixel_data,
    input  pixel_addr, busy, frame_done, ws_dout
  );

  // Driver side
  modport slave (
    input  start, pixel_data,
    output pixel_addr, busy, frame_done, ws_dout
  );
`endif
endinterface

// File: rtl/ws2812_driver.sv
// WS2812B frame serialiser. Fetches 24-bit GRB words from a registered
// frame store (one clk read latency), streams them MSB first with no gap
// between pixels, then holds the line low for the latch period.
// Optional feature macro: WS2812_BRIGHTNESS_EN scales each channel by
// (brightness+1)/256 when a word is loaded into the shift register.
module ws2812_driver #(
  parameter int NUM_PIXELS   = 64,
  parameter int T_BIT        = 15,
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int LATCH_CYCLES = 600
) (
  input logic     clk,
  input logic     rst_n,
  ws2812_if.slave bus
);

  localparam int ADDR_W = (NUM_PIXELS > 1)   ? $clog2(NUM_PIXELS)   : 1;
  localparam int CNT_W  = (T_BIT > 1)        ? $clog2(T_BIT)        : 1;
  localparam int LAT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0]  T0H_C      = CNT_W'(T0H);
  localparam logic [CNT_W-1:0]  T1H_C      = CNT_W'(T1H);
  localparam logic [LAT_W-1:0]  LATCH_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [4:0]        IDX_LAST   = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH
  } state_e;

  state_e            state_q, state_d;
  logic              fetch_q, fetch_d;        // FETCH sub-step: 0 = addr out, 1 = capture
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;    // clk within the current bit cell
  logic [4:0]        bit_idx_q, bit_idx_d;    // bit within the current pixel
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;    // pixel being transmitted
  logic [ADDR_W-1:0] addr_q, addr_d;          // prefetch address, saturating
  logic [LAT_W-1:0]  latch_cnt_q, latch_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [23:0]       load_word;

`ifdef WS2812_BRIGHTNESS_EN
  // (c * (b + 1)) >> 8; the product never exceeds 16 bits (255 * 256)
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  // Brightness is applied only here, so a change lands on a pixel boundary
  always_comb begin
    load_word = {scale(bus.pixel_data[23:16], bus.brightness),
                 scale(bus.pixel_data[15:8],  bus.brightness),
                 scale(bus.pixel_data[7:0],   bus.brightness)};
  end
`else
  // Channels pass through unmodified
  always_comb begin
    load_word = bus.pixel_data;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    fetch_d     = fetch_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    pix_cnt_d   = pix_cnt_q;
    addr_d      = addr_q;
    latch_cnt_d = latch_cnt_q;
    shift_d     = shift_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = FETCH;
          fetch_d     = 1'b0;
          addr_d      = '0;
          pix_cnt_d   = '0;
          bit_cnt_d   = '0;
          bit_idx_d   = '0;
          latch_cnt_d = '0;
        end
      end

      FETCH: begin
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          // Word 0 is on pixel_data now; prefetch the next address
          fetch_d   = 1'b0;
          shift_d   = load_word;
          state_d   = SEND;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
        end
      end

      SEND: begin
        if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          bit_cnt_d = '0;
          if (bit_idx_q != IDX_LAST) begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {shift_q[22:0], 1'b0};
          end else begin
            bit_idx_d = '0;
            if (pix_cnt_q == ADDR_LAST) begin
              state_d     = LATCH;
              latch_cnt_d = '0;
            end else begin
              // Prefetched word is already valid: reload with no idle clk
              pix_cnt_d = pix_cnt_q + 1'b1;
              shift_d   = load_word;
              if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
            end
          end
        end
      end

      LATCH: begin
        if (latch_cnt_q == LATCH_LAST) begin
          state_d     = IDLE;
          latch_cnt_d = '0;
          addr_d      = '0;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so each one leaves a flop
    busy_d = (state_d != IDLE);
    dout_d = (state_d == SEND) && (bit_cnt_d < (shift_d[23] ? T1H_C : T0H_C));
    done_d = (state_d == LATCH) && (latch_cnt_d == LATCH_LAST);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_q     <= 1'b0;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      pix_cnt_q   <= '0;
      addr_q      <= '0;
      latch_cnt_q <= '0;
      shift_q     <= '0;
      dout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      fetch_q     <= fetch_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      addr_q      <= addr_d;
      latch_cnt_q <= latch_cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pixel_addr = addr_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.ws_dout    = dout_q;

endmodule
